chimera_clu_iso_ctrl: RTL

Initiator side of the per-cluster isolation handshake. For each external cluster it drives the isolation request into the cluster domain and consumes that domain's isolated acknowledgement. Runs an isolate → clock-gate → hold-off sequence for power-down and a clock-on → reset-pulse → de-isolate sequence for wake-up. Sits in the SoC clock domain between the chimera register file (requests and status) and the cluster domain plus the clock gates.

---
 rtl/chimera_pkg.sv | 27 ++
 rtl/chimera_clu_iso_fsm.sv | 123 ++++++++++++
 rtl/chimera_clu_iso_ctrl.sv | 50 +++++
 3 files changed

// File: rtl/chimera_pkg.sv
// Shared types and defaults for the chimera cluster isolation controller.
// Optional feature macro used by the controller: CHIMERA_CLU_ISO_IRQ_EN.
package chimera_pkg;

    typedef enum logic [2:0] {
        ACTIVE = 3'd0,
        ISO    = 3'd1,
        SETTLE = 3'd2,
        OFF    = 3'd3,
        WAKE   = 3'd4,
        DEISO  = 3'd5
    } clu_iso_state_e;

    localparam int unsigned CluIsoTimeoutCycles = 1024;
    localparam int unsigned CluIsoResetCycles   = 16;
    localparam int unsigned CluIsoSettleCycles  = 4;

    // Wide enough to hold the largest load value; never narrower than 1 bit.
    function automatic int unsigned clu_iso_cnt_w(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/chimera_clu_iso_fsm.sv
// Single-channel isolation FSM with its down-counter and sticky timeout flag.
// CHIMERA_CLU_ISO_IRQ_EN adds a one-cycle irq pulse on entry to OFF or return to ACTIVE.
module chimera_clu_iso_fsm
    import chimera_pkg::*;
#(
    parameter int unsigned TimeoutCycles   = CluIsoTimeoutCycles,
    parameter int unsigned ResetCycles     = CluIsoResetCycles,
    parameter int unsigned ClkSettleCycles = CluIsoSettleCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic pwr_down_req,
    input  logic timeout_clr,
    input  logic isolated,
    output logic isolate,
    output logic clk_en,
    output logic clu_rst,
    output logic busy,
    output logic off,
`ifdef CHIMERA_CLU_ISO_IRQ_EN
    output logic irq,
`endif
    output logic timeout
);

    localparam int unsigned CntW = clu_iso_cnt_w(TimeoutCycles, ResetCycles, ClkSettleCycles);
    localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles);
    localparam logic [CntW-1:0] ResetLoad   = CntW'(ResetCycles);
    localparam logic [CntW-1:0] SettleLoad  = CntW'(ClkSettleCycles);

    clu_iso_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic tmo_set;
    logic iso_d, clk_en_d, clu_rst_d, busy_d, off_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_set   = 1'b0;
        case (state_q)
            ACTIVE: if (pwr_down_req) begin
                cnt_d   = TimeoutLoad;
                state_d = ISO;
            end
            // Ack wins over an expiring counter.
            ISO: if (isolated) begin
                cnt_d   = SettleLoad;
                state_d = SETTLE;
            end else if (cnt_q == '0) begin
                tmo_set = 1'b1;
                state_d = DEISO;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            SETTLE: if (cnt_q == '0) state_d = OFF;
                    else cnt_d = cnt_q - 1'b1;
            OFF: if (!pwr_down_req) begin
                cnt_d   = ResetLoad;
                state_d = WAKE;
            end
            WAKE: if (cnt_q == '0) begin
                cnt_d   = TimeoutLoad;
                state_d = DEISO;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            DEISO: if (!isolated) begin
                state_d = ACTIVE;
            end else if (cnt_q == '0) begin
                tmo_set = 1'b1;
                state_d = ACTIVE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = ACTIVE;
        endcase

        // Output decode of the next state so the registered outputs track state_q.
        iso_d     = 1'b0;
        clk_en_d  = 1'b1;
        clu_rst_d = 1'b0;
        busy_d    = 1'b0;
        off_d     = 1'b0;
        case (state_d)
            ISO, SETTLE: begin iso_d = 1'b1; busy_d = 1'b1; end
            OFF:         begin iso_d = 1'b1; clk_en_d = 1'b0; clu_rst_d = 1'b1; off_d = 1'b1; end
            WAKE:        begin iso_d = 1'b1; clu_rst_d = 1'b1; busy_d = 1'b1; end
            DEISO:       busy_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
            isolate <= 1'b0;
            clk_en  <= 1'b1;
            clu_rst <= 1'b0;
            busy    <= 1'b0;
            off     <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            isolate <= iso_d;
            clk_en  <= clk_en_d;
            clu_rst <= clu_rst_d;
            busy    <= busy_d;
            off     <= off_d;
            timeout <= tmo_set | (timeout & ~timeout_clr);
        end
    end

`ifdef CHIMERA_CLU_ISO_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= ((state_d == OFF) && (state_q != OFF)) ||
                        ((state_q == DEISO) && (state_d == ACTIVE));
    end
`endif

endmodule

// File: rtl/chimera_clu_iso_ctrl.sv
// Per-cluster isolation handshake initiator: one independent FSM channel per cluster.
// CHIMERA_CLU_ISO_IRQ_EN adds irq_o.
module chimera_clu_iso_ctrl
    import chimera_pkg::*;
#(
    parameter int unsigned ExtClusters     = 5,
    parameter int unsigned TimeoutCycles   = CluIsoTimeoutCycles,
    parameter int unsigned ResetCycles     = CluIsoResetCycles,
    parameter int unsigned ClkSettleCycles = CluIsoSettleCycles
) (
    input  logic                   soc_clk_i,
    input  logic                   rst_i,
    input  logic [ExtClusters-1:0] pwr_down_req_i,
    input  logic [ExtClusters-1:0] timeout_clr_i,
    input  logic [ExtClusters-1:0] isolated_i,
    output logic [ExtClusters-1:0] isolate_o,
    output logic [ExtClusters-1:0] clu_clk_en_o,
    output logic [ExtClusters-1:0] clu_rst_o,
    output logic [ExtClusters-1:0] busy_o,
    output logic [ExtClusters-1:0] off_o,
`ifdef CHIMERA_CLU_ISO_IRQ_EN
    output logic [ExtClusters-1:0] irq_o,
`endif
    output logic [ExtClusters-1:0] timeout_o
);

    for (genvar c = 0; c < ExtClusters; c++) begin : gen_ch
        chimera_clu_iso_fsm #(
            .TimeoutCycles  (TimeoutCycles),
            .ResetCycles    (ResetCycles),
            .ClkSettleCycles(ClkSettleCycles)
        ) u_fsm (
            .clk         (soc_clk_i),
            .rst         (rst_i),
            .pwr_down_req(pwr_down_req_i[c]),
            .timeout_clr (timeout_clr_i[c]),
            .isolated    (isolated_i[c]),
            .isolate     (isolate_o[c]),
            .clk_en      (clu_clk_en_o[c]),
            .clu_rst     (clu_rst_o[c]),
            .busy        (busy_o[c]),
            .off         (off_o[c]),
`ifdef CHIMERA_CLU_ISO_IRQ_EN
            .irq         (irq_o[c]),
`endif
            .timeout     (timeout_o[c])
        );
    end

endmodule
